// File: rtl/nic8_pkg.sv
// Shared definitions for the program loader.
//   ld_state_e         : loader FSM states (wait for length, payload, checksum, run, error)
//   LEN_ZERO_MEANS_256 : a length header of 0 announces a 256-byte payload
//   frame_len()        : decodes a length header into a payload byte count
package nic8_pkg;

  typedef enum logic [2:0] {
    StWaitLen,
    StData,
    StCheck,
    StRun,
    StError
  } ld_state_e;

  localparam bit LEN_ZERO_MEANS_256 = 1'b1;

  function automatic logic [8:0] frame_len(input logic [7:0] hdr);
    if (LEN_ZERO_MEANS_256 && (hdr == 8'd0)) begin
      return 9'd256;
    end
    return {1'b0, hdr};
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: writer side of the CPU program memory.
// Receives frames of {length, payload..., checksum} over a valid/ready stream,
// writes each payload byte to memory one cycle after it is accepted, and keeps
// the CPU held in reset until a frame with a matching 8-bit sum has been loaded.
//   clk, reset         : clock, synchronous active-high reset
//   in_data/in_valid   : stream byte and its valid
//   in_ready           : high whenever reset is low (no backpressure)
//   wr_en/wr_addr/wr_data : program memory write port (registered)
//   cpu_hold           : ORed into the CPU reset
//   load_done/load_err : result of the most recent frame
module prog_loader
  import nic8_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);

  ld_state_e         state_q, state_d;
  logic [8:0]        rem_q, rem_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              accept;

  assign in_ready = !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      case (state_q)
        // Idle, running and failed states all treat a byte as a fresh length header.
        StWaitLen, StRun, StError: begin
          rem_d   = frame_len(in_data);
          sum_d   = 8'd0;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          state_d = StData;
        end
        StData: begin
          wr_en_d   = 1'b1;
          wr_addr_d = StartAddr + idx_q;
          wr_data_d = in_data;
          sum_d     = sum_q + in_data;
          idx_d     = idx_q + ADDR_W'(1);
          rem_d     = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (in_data == sum_q) begin
            state_d = StRun;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
        default: state_d = StWaitLen;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StWaitLen;
      rem_q     <= 9'd0;
      idx_q     <= '0;
      sum_q     <= 8'd0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= StartAddr;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (start address 0 and F0) share one stream.
// The driver knows the role of every byte it sends (header, payload, checksum) and
// updates the expected post-edge outputs from the frame contents; a negedge process
// compares both DUTs against those expectations on every cycle.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;

  logic       rdy0, rdy1, wen0, wen1, hold0, hold1, done0, done1, err0, err1;
  logic [7:0] addr0, addr1, data0, data1;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .START_ADDR(0)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .wr_en(wen0), .wr_addr(addr0), .wr_data(data0), .cpu_hold(hold0),
    .load_done(done0), .load_err(err0)
  );

  prog_loader #(.ADDR_W(8), .START_ADDR(240)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .wr_en(wen1), .wr_addr(addr1), .wr_data(data1), .cpu_hold(hold1),
    .load_done(done1), .load_err(err1)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs after the most recent edge.
  logic       e_wen, e_hold, e_done, e_err;
  logic [7:0] e_data, e_addr0, e_addr1;
  bit         check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready0", rdy0, !reset);
      chk("in_ready1", rdy1, !reset);
      chk("wr_en0", wen0, e_wen);
      chk("wr_en1", wen1, e_wen);
      chk("wr_addr0", addr0, e_addr0);
      chk("wr_addr1", addr1, e_addr1);
      chk("wr_data0", data0, e_data);
      chk("wr_data1", data1, e_data);
      chk("cpu_hold0", hold0, e_hold);
      chk("cpu_hold1", hold1, e_hold);
      chk("load_done0", done0, e_done);
      chk("load_done1", done1, e_done);
      chk("load_err0", err0, e_err);
      chk("load_err1", err1, e_err);
    end
  end

  function automatic void model_reset();
    e_wen   = 1'b0;
    e_hold  = 1'b1;
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_data  = 8'h00;
    e_addr0 = 8'h00;
    e_addr1 = 8'hF0;
  endfunction

  function automatic logic [7:0] fsum(input logic [7:0] p[$]);
    int s = 0;
    foreach (p[i]) s += int'(p[i]);
    return 8'(s % 256);
  endfunction

  // One accepted byte: present it, take the edge, then drop valid.
  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      e_wen = 1'b0;
    end
  endtask

  task automatic reset_edge(input logic valid_during);
    reset    = 1'b1;
    in_valid = valid_during;
    in_data  = 8'($urandom);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    model_reset();
  endtask

  task automatic hdr(input int n);
    put(8'(n));
    e_wen  = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    e_hold = 1'b1;
  endtask

  task automatic pay(input logic [7:0] b, input int i);
    put(b);
    e_wen   = 1'b1;
    e_data  = b;
    e_addr0 = 8'(i);
    e_addr1 = 8'(240 + i);
  endtask

  task automatic send_frame(input logic [7:0] p[$], input logic [7:0] c,
                            input int gmin, input int gmax);
    logic [7:0] s;
    s = fsum(p);
    hdr(p.size());
    idle($urandom_range(gmax, gmin));
    foreach (p[i]) begin
      pay(p[i], i);
      if (p.size() == 256 && i == 16) begin
        chk("wrap17_addr_f0", addr1, 32'h00);
        chk("wrap17_addr_00", addr0, 32'h10);
      end
      idle($urandom_range(gmax, gmin));
    end
    put(c);
    e_wen  = 1'b0;
    e_done = (c == s);
    e_err  = (c != s);
    e_hold = (c != s);
    idle($urandom_range(gmax, gmin));
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    @(posedge clk);
    check_en = 1'b1;
    reset_edge(1'b1);

    // Basic good frame, back to back.
    q = '{8'h10, 8'h20, 8'h30};
    send_frame(q, 8'h60, 0, 0);
    chk("t1_done_lit", done0, 32'h1);
    chk("t1_hold_lit", hold0, 32'h0);
    chk("t1_last_addr_lit", addr0, 32'h2);
    chk("t1_last_data_lit", data0, 32'h30);

    // Bad checksum, then a recovering one-byte frame.
    send_frame(q, 8'h61, 0, 0);
    chk("t2_err_lit", err0, 32'h1);
    chk("t2_hold_lit", hold0, 32'h1);
    q = '{8'hAA};
    send_frame(q, 8'hAA, 0, 0);
    chk("t2b_done_lit", done0, 32'h1);
    chk("t2b_err_lit", err0, 32'h0);
    chk("t2b_addr_lit", addr0, 32'h0);

    // 256-byte frame (header 00) covering the whole address space.
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(8'(i));
    send_frame(q, 8'h80, 0, 0);
    chk("t3_done_lit", done0, 32'h1);
    chk("t3_last_addr_f0", addr1, 32'hEF);

    // Gapped frame: valid low five cycles between bytes.
    q = '{8'h05, 8'h06};
    send_frame(q, 8'h0B, 5, 5);
    chk("t4_done_lit", done1, 32'h1);

    // New header while running, then reset with a payload byte on the stream.
    hdr(1);
    chk("t5_hold_rise_lit", hold0, 32'h1);
    chk("t5_done_clear_lit", done0, 32'h0);
    reset_edge(1'b1);
    idle(2);
    chk("t5_no_write_lit", wen0, 32'h0);
    chk("t5_hold_lit", hold0, 32'h1);

    // Randomised frames, gaps, bad checksums and aborted frames.
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(12, 1);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      if ($urandom_range(7, 0) == 0) begin
        hdr(n);
        for (int i = 0; i < $urandom_range(n - 1, 0); i++) begin
          pay(q[i], i);
          idle($urandom_range(1, 0));
        end
        reset_edge(1'($urandom));
      end else begin
        s = fsum(q);
        if ($urandom_range(3, 0) == 0) s = s ^ 8'($urandom_range(255, 1));
        send_frame(q, s, 0, 2);
      end
    end

    idle(2);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
